fifo_top: RTL and testbench

FIFO_TOP -- requirements
Module: fifo_top

---
 rtl/fifo_top.sv | 88 ++++++++
 tb/tb_fifo_top.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fifo_top.sv
// Single-clock synchronous FIFO.
//
// Storage is 2^(ADDR_WIDTH-1) entries of DATA_WIDTH bits. The read and write
// pointers carry one extra wrap bit, so full and empty can be told apart when
// the storage indices are equal.
//
// Ports:
//   w_clk    in   sole clock, all state updates on its rising edge
//   w_rst_n  in   asynchronous active-low reset (pointers and r_data)
//   w_en     in   write request
//   w_data   in   write data, stored when the write is accepted
//   r_en     in   read request
//   r_data   out  registered read data, valid the cycle after a read is accepted
//   w_full   out  FIFO holds 2^(ADDR_WIDTH-1) entries
//   r_empty  out  FIFO holds no entries
module fifo_top #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  w_clk,
  input  logic                  w_rst_n,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  w_full,
  output logic                  r_empty
);

  localparam int unsigned IdxWidth = ADDR_WIDTH - 1;
  localparam int unsigned Depth    = 1 << IdxWidth;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;

  logic [IdxWidth-1:0] widx, ridx;
  logic                wr_accept, rd_accept;

  assign widx = wptr_q[IdxWidth-1:0];
  assign ridx = rptr_q[IdxWidth-1:0];

  // Flags come straight from the registered pointers, so they are evaluated
  // before the edge: a write while full or a read while empty is dropped.
  assign r_empty = (wptr_q == rptr_q);
  assign w_full  = (widx == ridx) && (wptr_q[ADDR_WIDTH-1] != rptr_q[ADDR_WIDTH-1]);

  assign wr_accept = w_en && !w_full;
  assign rd_accept = r_en && !r_empty;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    r_data_d = r_data_q;
    if (wr_accept) begin
      wptr_d = wptr_q + ADDR_WIDTH'(1);
    end
    if (rd_accept) begin
      rptr_d   = rptr_q + ADDR_WIDTH'(1);
      r_data_d = mem_q[ridx];
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      r_data_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      r_data_q <= r_data_d;
    end
  end

  // Storage is deliberately not reset; clearing the pointers makes old
  // contents unreachable. Writes are gated by reset so a held reset is inert.
  always_ff @(posedge w_clk) begin
    if (w_rst_n && wr_accept) begin
      mem_q[widx] <= w_data;
    end
  end

  assign r_data = r_data_q;

endmodule

// File: tb/tb_fifo_top.sv
module tb_fifo_top;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << (AW - 1);

  logic          w_clk = 1'b0;
  logic          w_rst_n = 1'b1;
  logic          w_en = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          r_en = 1'b0;
  logic [DW-1:0] r_data;
  logic          w_full;
  logic          r_empty;

  int n_cmp  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  // Behavioural model: a queue of stored values plus the last value read.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_data = '0;

  fifo_top #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .w_clk  (w_clk),
    .w_rst_n(w_rst_n),
    .w_en   (w_en),
    .w_data (w_data),
    .r_en   (r_en),
    .r_data (r_data),
    .w_full (w_full),
    .r_empty(r_empty)
  );

  always #5 w_clk = ~w_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge w_rst_n) begin
    model_q.delete();
    exp_data = '0;
  end

  always @(posedge w_clk) begin
    if (w_rst_n) begin
      bit was_full, was_empty;
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      if (r_en && !was_empty) exp_data = model_q.pop_front();
      if (w_en && !was_full) model_q.push_back(w_data);
    end
  end

  // Compare process: outputs against the model on every falling edge.
  always @(negedge w_clk) begin
    if (started) begin
      check("model_empty", {31'b0, r_empty}, {31'b0, model_q.size() == 0});
      check("model_full", {31'b0, w_full}, {31'b0, model_q.size() == DEPTH});
      check("model_rdata", {24'b0, r_data}, {24'b0, exp_data});
    end
  end

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
    w_en   = we;
    w_data = wd;
    r_en   = re;
    @(negedge w_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 w_rst_n = 1'b0;
    #1;
    check("reset_empty", {31'b0, r_empty}, 32'd1);
    check("reset_full", {31'b0, w_full}, 32'd0);
    check("reset_rdata", {24'b0, r_data}, 32'd0);
    @(negedge w_clk);
    w_rst_n = 1'b1;
    started = 1'b1;

    // Fill with 1..8, then try a 9th write.
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0);
    check("fill_full", {31'b0, w_full}, 32'd1);
    check("fill_empty", {31'b0, r_empty}, 32'd0);
    step(1'b1, 8'd9, 1'b0);
    check("ovf_full", {31'b0, w_full}, 32'd1);

    // Drain 1..8, then a rejected 9th read.
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 8'd0, 1'b1);
      check("drain_data", {24'b0, r_data}, 32'(i));
    end
    check("drain_empty", {31'b0, r_empty}, 32'd1);
    step(1'b0, 8'd0, 1'b1);
    check("udf_hold", {24'b0, r_data}, 32'd8);

    // Four stored, then simultaneous read/write of 9..18.
    for (int i = 21; i <= 24; i++) step(1'b1, DW'(i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, DW'(9 + i), 1'b1);
      check("sim_data", {24'b0, r_data}, (i < 4) ? 32'(21 + i) : 32'(9 + i - 4));
      check("sim_flags", {30'b0, w_full, r_empty}, 32'd0);
    end
    for (int i = 15; i <= 18; i++) begin
      step(1'b0, 8'd0, 1'b1);
      check("sim_tail", {24'b0, r_data}, 32'(i));
    end

    // Streaming 1..20 across pointer wraps.
    step(1'b1, 8'd1, 1'b0);
    for (int j = 1; j <= 19; j++) begin
      step(1'b1, DW'(j + 1), 1'b1);
      check("stream_data", {24'b0, r_data}, 32'(j));
    end
    step(1'b0, 8'd0, 1'b1);
    check("stream_last", {24'b0, r_data}, 32'd20);
    check("stream_empty", {31'b0, r_empty}, 32'd1);

    // Reset mid-cycle with 5 entries stored.
    for (int i = 1; i <= 5; i++) step(1'b1, DW'(30 + i), 1'b0);
    step(1'b0, 8'd0, 1'b1);
    check("pre_rst_data", {24'b0, r_data}, 32'd31);
    #2 w_rst_n = 1'b0;
    #1;
    check("rst_empty", {31'b0, r_empty}, 32'd1);
    check("rst_full", {31'b0, w_full}, 32'd0);
    check("rst_rdata", {24'b0, r_data}, 32'd0);
    @(negedge w_clk);
    step(1'b1, 8'd77, 1'b1);
    check("rst_hold_empty", {31'b0, r_empty}, 32'd1);
    w_rst_n = 1'b1;
    step(1'b1, 8'd42, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    check("post_rst_data", {24'b0, r_data}, 32'd42);
    check("post_rst_empty", {31'b0, r_empty}, 32'd1);

    // Full plus simultaneous request: read wins, 99 dropped.
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0);
    step(1'b1, 8'd99, 1'b1);
    check("full_rw_data", {24'b0, r_data}, 32'd1);
    check("full_rw_full", {31'b0, w_full}, 32'd0);
    for (int i = 2; i <= 8; i++) begin
      step(1'b0, 8'd0, 1'b1);
      check("full_rw_drain", {24'b0, r_data}, 32'(i));
    end
    check("full_rw_empty", {31'b0, r_empty}, 32'd1);

    // Empty plus simultaneous request: write accepted, no write-through.
    step(1'b1, 8'd55, 1'b1);
    check("empty_rw_data", {24'b0, r_data}, 32'd8);
    check("empty_rw_empty", {31'b0, r_empty}, 32'd0);
    step(1'b0, 8'd0, 1'b1);
    check("empty_rw_read", {24'b0, r_data}, 32'd55);

    step(1'b0, 8'd0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
